avalon_master_arbiter: RTL and testbench
========================================

// Module: avalon_master_arbiter
// PURPOSE
//   Shares the single Avalon-MM master port toward the PCIe/SDRAM fabric between NUM_REQ
//   requesters (CSR-driven custom slaves, DMA engines). Grants are round-robin and one command
//   at a time. Granted commands pass through unmodified. Read responses are routed back to
//   their issuers in order, using a tag FIFO, so pipelined reads stay correct.
// PARAMETERS
//   NUM_REQ       2   number of requesters (2..8)
//   ADDRESSWIDTH  26  Avalon master address width
//   DATAWIDTH     32  data width
//   MAX_PENDING   4   maximum outstanding reads; this is the tag FIFO depth (power of 2)
// PORTS
//   clk                  in   1                       single clock, all logic posedge
//   reset                in   1                       asynchronous, active-high
//   req_address          in   NUM_REQ x ADDRESSWIDTH  per-requester address
//   req_writedata        in   NUM_REQ x DATAWIDTH     per-requester write data
//   req_write            in   NUM_REQ                 per-requester write command
//   req_read             in   NUM_REQ                 per-requester read command
//   req_waitrequest      out  NUM_REQ                 per-requester stall
//   req_readdata         out  DATAWIDTH               read data, broadcast to all requesters
//   req_readdatavalid    out  NUM_REQ                 read data valid, one-hot to the issuer
//   master_address       out  ADDRESSWIDTH            to fabric
//   master_writedata     out  DATAWIDTH               to fabric
//   master_write         out  1                       to fabric
//   master_read          out  1                       to fabric
//   master_readdata      in   DATAWIDTH               from fabric
//   master_readdatavalid in   1                       from fabric
//   master_waitrequest   in   1                       from fabric
//   pending_reads        out  $clog2(MAX_PENDING)+1   reads issued but not yet returned
//   err_orphan_rdv       out  1                       sticky: readdatavalid seen with no pending read
// BEHAVIOUR
//   Reset (async): state=ARB, grant=0, rr_ptr=0 (requester 0 has highest priority first),
//     FIFO empty, err=0. All master_* outputs are 0. All req_waitrequest bits are 1.
//     No req_readdatavalid bit is set. A reset mid-transfer drops in-flight tags.
//   Requester n is "requesting" when req_write[n] | req_read[n].
//   State ARB:
//     - Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
//     - The first requesting index is registered as grant, and the state moves to OWN.
//     - If nothing is requesting, stay in ARB.
//     - Arbitration costs 1 cycle; the fabric sees no command while in ARB.
//   State OWN:
//     - master_address and master_writedata are driven combinationally from the granted requester.
//     - master_write = req_write[grant].
//     - master_read = req_read[grant] & !fifo_full.
//     - req_waitrequest[grant] = master_waitrequest | (req_read[grant] & fifo_full).
//     - Every other req_waitrequest bit is 1.
//     - A command is accepted when (master_write | master_read) & !master_waitrequest.
//       On acceptance: a read pushes grant into the tag FIFO, rr_ptr becomes grant+1 (wrapping),
//       and the state returns to ARB.
//     - If the granted requester drops both read and write before acceptance, return to ARB
//       with no FIFO push and rr_ptr unchanged.
//     - Asserting req_read and req_write together is illegal. If it happens, write wins and
//       master_read is forced to 0.
//   Responses:
//     - req_readdata = master_readdata at all times.
//     - On master_readdatavalid with the FIFO non-empty, set req_readdatavalid[fifo_head] in the
//       same cycle (combinational) and pop the FIFO.
//     - On master_readdatavalid with the FIFO empty, set err_orphan_rdv (sticky until reset)
//       and assert no req_readdatavalid bit.
//     - A push and a pop in the same cycle are both legal; the count is unchanged.
//     - When full (count == MAX_PENDING), new reads stall. Writes still proceed.
//   pending_reads equals the FIFO count, registered.
// STRUCTURE
//   Package avalon_arb_pkg holds:
//     - typedef enum logic {ARB, OWN} arb_state_t
//     - function rr_pick(req_vec, ptr), returning the next index
//   Sub-module arb_tag_fifo holds: parameters DEPTH and WIDTH=$clog2(NUM_REQ), a synchronous
//     push/pop interface, and outputs full, empty and count.
//   The top level holds the FSM, the muxes and the response routing.
// TESTING
//   1. Reset, then idle: req_waitrequest=2'b11, master_write=master_read=0, pending_reads=0.
//   2. R0 writes 0x08000000<-0xF00BF00B with waitrequest held 3 cycles:
//      master_write stays high 4 cycles with a stable address; R0 sees waitrequest release in
//      cycle 4 only; back in ARB next cycle.
//   3. R0 and R1 both hold continuous writes:
//      grants alternate 0,1,0,1; neither requester is starved over 8 transfers.
//   4. R1 issues 4 reads, no rdv returned: 5th read stalls (master_read=0, pending_reads=4).
//      Then 1 rdv with data 0xDEADF00B: req_readdatavalid=2'b10, and the 5th read issues.
//   5. Interleave reads R0,R1,R0, with rdv data A,B,C returned later:
//      routing is 01,10,01 in order; same-cycle push/pop leaves the count unchanged.
//   6. rdv with the FIFO empty: err_orphan_rdv goes 1 and stays 1.
//      Async reset mid-OWN: outputs clear immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/avalon_arb_pkg.sv
// rtl/avalon_arb_pkg.sv - shared types and round-robin pick helper for the Avalon master arbiter
//   Contents: arb_state_t (ARB/OWN), RR_MAX_REQ, rr_pick(req_vec, ptr, num_req) -> index
package avalon_arb_pkg;

    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } arb_state_t;

    // Upper bound on requesters the pick helper can scan; callers zero-pad unused bits.
    localparam int RR_MAX_REQ = 8;

    // First requesting index at or after ptr, wrapping modulo num_req.
    // Returns ptr when nothing is requesting; the caller qualifies with |req_vec.
    function automatic logic [2:0] rr_pick(
        input logic [RR_MAX_REQ-1:0] req_vec,
        input logic [2:0]            ptr,
        input int                    num_req
    );
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < RR_MAX_REQ; i++) begin
            idx = (int'(ptr) + i) % num_req;
            if (i < num_req && !found && req_vec[idx]) begin
                pick  = 3'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// rtl/arb_tag_fifo.sv - tag FIFO recording which requester issued each outstanding read
//   Ports: clk, reset (async, active-high), push/push_tag, pop, head (tag at the read pointer),
//          full, empty, count (occupancy, registered)
module arb_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_tag,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_tag;
    end

endmodule

// File: rtl/avalon_master_arbiter.sv
// rtl/avalon_master_arbiter.sv - round-robin share of one Avalon-MM master among NUM_REQ requesters
//   Requester side: req_address, req_writedata, req_write, req_read (in);
//                   req_waitrequest, req_readdata, req_readdatavalid (out)
//   Fabric side:    master_address, master_writedata, master_write, master_read (out);
//                   master_readdata, master_readdatavalid, master_waitrequest (in)
//   Status:         pending_reads (outstanding reads), err_orphan_rdv (sticky)
module avalon_master_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int ADDRESSWIDTH = 26,
    parameter int DATAWIDTH    = 32,
    parameter int MAX_PENDING  = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_REQ-1:0][ADDRESSWIDTH-1:0]      req_address,
    input  logic [NUM_REQ-1:0][DATAWIDTH-1:0]         req_writedata,
    input  logic [NUM_REQ-1:0]                        req_write,
    input  logic [NUM_REQ-1:0]                        req_read,
    output logic [NUM_REQ-1:0]                        req_waitrequest,
    output logic [DATAWIDTH-1:0]                      req_readdata,
    output logic [NUM_REQ-1:0]                        req_readdatavalid,
    output logic [ADDRESSWIDTH-1:0]                   master_address,
    output logic [DATAWIDTH-1:0]                      master_writedata,
    output logic                                      master_write,
    output logic                                      master_read,
    input  logic [DATAWIDTH-1:0]                      master_readdata,
    input  logic                                      master_readdatavalid,
    input  logic                                      master_waitrequest,
    output logic [$clog2(MAX_PENDING):0]              pending_reads,
    output logic                                      err_orphan_rdv
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t              state;
    logic [GW-1:0]           grant;
    logic [GW-1:0]           rr_ptr;
    logic [GW-1:0]           next_ptr;
    logic [NUM_REQ-1:0]      req_any;
    logic [RR_MAX_REQ-1:0]   req_pad;
    logic [2:0]              pick;
    logic                    own;
    logic                    cur_write;
    logic                    cur_read;
    logic                    accept;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [GW-1:0]           fifo_head;

    assign req_any  = req_write | req_read;
    assign req_pad  = RR_MAX_REQ'(req_any);
    assign pick     = rr_pick(req_pad, 3'(rr_ptr), NUM_REQ);
    assign next_ptr = (grant == GW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

    assign own       = (state == OWN);
    assign cur_write = req_write[grant];
    // Read together with write is illegal; write wins.
    assign cur_read  = req_read[grant] & ~cur_write;

    assign master_address   = own ? req_address[grant]   : '0;
    assign master_writedata = own ? req_writedata[grant] : '0;
    assign master_write     = own & cur_write;
    assign master_read      = own & cur_read & ~fifo_full;

    assign accept    = (master_write | master_read) & ~master_waitrequest;
    assign fifo_push = accept & master_read;
    assign fifo_pop  = master_readdatavalid & ~fifo_empty;

    always_comb begin
        req_waitrequest = '1;
        if (own) begin
            req_waitrequest[grant] = master_waitrequest | (cur_read & fifo_full);
        end
    end

    assign req_readdata = master_readdata;

    always_comb begin
        req_readdatavalid = '0;
        if (fifo_pop) begin
            req_readdatavalid[fifo_head] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ARB;
            grant          <= '0;
            rr_ptr         <= '0;
            err_orphan_rdv <= 1'b0;
        end else begin
            if (master_readdatavalid & fifo_empty) begin
                err_orphan_rdv <= 1'b1;
            end
            case (state)
                ARB: begin
                    if (|req_any) begin
                        grant <= GW'(pick);
                        state <= OWN;
                    end
                end
                OWN: begin
                    if (accept) begin
                        rr_ptr <= next_ptr;
                        state  <= ARB;
                    end else if (!req_any[grant]) begin
                        // Requester withdrew before the fabric took the command.
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    arb_tag_fifo #(
        .DEPTH (MAX_PENDING),
        .WIDTH (GW)
    ) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_tag (grant),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (pending_reads)
    );

endmodule

// File: tb/tb_avalon_master_arbiter.sv
// tb/tb_avalon_master_arbiter.sv - scoreboard bench for avalon_master_arbiter
module tb_avalon_master_arbiter;

    localparam int NR = 2;
    localparam int AW = 28;
    localparam int DW = 32;
    localparam int MP = 4;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic [NR-1:0][AW-1:0]    req_address = '0;
    logic [NR-1:0][DW-1:0]    req_writedata = '0;
    logic [NR-1:0]            req_write = '0;
    logic [NR-1:0]            req_read = '0;
    logic [NR-1:0]            req_waitrequest;
    logic [DW-1:0]            req_readdata;
    logic [NR-1:0]            req_readdatavalid;
    logic [AW-1:0]            master_address;
    logic [DW-1:0]            master_writedata;
    logic                     master_write;
    logic                     master_read;
    logic [DW-1:0]            master_readdata = '0;
    logic                     master_readdatavalid = 1'b0;
    logic                     master_waitrequest = 1'b0;
    logic [$clog2(MP):0]      pending_reads;
    logic                     err_orphan_rdv;

    avalon_master_arbiter #(
        .NUM_REQ(NR), .ADDRESSWIDTH(AW), .DATAWIDTH(DW), .MAX_PENDING(MP)
    ) dut (
        .clk(clk), .reset(reset),
        .req_address(req_address), .req_writedata(req_writedata),
        .req_write(req_write), .req_read(req_read),
        .req_waitrequest(req_waitrequest), .req_readdata(req_readdata),
        .req_readdatavalid(req_readdatavalid),
        .master_address(master_address), .master_writedata(master_writedata),
        .master_write(master_write), .master_read(master_read),
        .master_readdata(master_readdata), .master_readdatavalid(master_readdatavalid),
        .master_waitrequest(master_waitrequest),
        .pending_reads(pending_reads), .err_orphan_rdv(err_orphan_rdv)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: outstanding reads in issue order, their count, and the sticky error.
    int          exp_q[$];
    int          cnt = 0;
    bit          err_m = 1'b0;
    logic [NR-1:0] acc_vec = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_write = '0;
        req_read = '0;
        master_readdatavalid = 1'b0;
        master_waitrequest = 1'b0;
        cnt = 0;
        exp_q.delete();
        err_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Command checker: any command a requester has handed off must appear on the fabric
    // exactly as issued; reads are recorded for the response scoreboard.
    int  c_who;
    int  c_nacc;
    bit  c_fab;
    bit  c_push;
    bit  c_pop;
    bit  c_orph;
    always begin
        @(negedge clk);
        if (reset) begin
            acc_vec = '0;
        end else begin
            check("pending_reads", 64'(pending_reads), 64'(cnt));
            check("err_orphan", 64'(err_orphan_rdv), 64'(err_m));
            acc_vec = ~req_waitrequest & (req_write | req_read);
            c_fab   = (master_write | master_read) & ~master_waitrequest;
            c_nacc  = $countones(acc_vec);
            c_push  = 1'b0;
            c_who   = 0;
            if (c_fab || c_nacc != 0) begin
                c_who = acc_vec[1] ? 1 : 0;
                check("one_grant", 64'(c_nacc), 64'd1);
                check("fabric_accept", 64'(c_fab), 64'd1);
                check("cmd_addr", 64'(master_address), 64'(req_address[c_who]));
                check("cmd_write", 64'(master_write), 64'(req_write[c_who]));
                check("cmd_read", 64'(master_read), 64'(req_read[c_who] & ~req_write[c_who]));
                if (req_write[c_who])
                    check("cmd_wdata", 64'(master_writedata), 64'(req_writedata[c_who]));
                c_push = req_read[c_who] & ~req_write[c_who];
            end
            if (cnt == MP) check("full_no_read", 64'(master_read), 64'd0);
            c_pop  = master_readdatavalid && cnt > 0;
            c_orph = master_readdatavalid && cnt == 0;
            @(posedge clk);
            if (!reset) begin
                if (c_push) exp_q.push_back(c_who);
                cnt = cnt + int'(c_push) - int'(c_pop);
                if (c_orph) err_m = 1'b1;
            end
        end
    end

    // Response monitor: each fabric readdatavalid goes to the oldest outstanding issuer.
    int            m_id;
    logic [NR-1:0] m_exp;
    always begin
        @(negedge clk);
        if (!reset) begin
            if (master_readdatavalid && exp_q.size() > 0) begin
                m_id  = exp_q.pop_front();
                m_exp = '0;
                m_exp[m_id] = 1'b1;
                check("rdv_route", 64'(req_readdatavalid), 64'(m_exp));
                check("rdv_data", 64'(req_readdata), 64'(master_readdata));
            end else begin
                check("rdv_none", 64'(req_readdatavalid), 64'd0);
            end
        end
    end

    task automatic issue_read(input int n);
        bit ok;
        ok = 1'b0;
        req_read[n] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!req_waitrequest[n]) ok = 1'b1;
            step();
            if (ok) break;
        end
        check("issue_read_timeout", 64'(ok), 64'd1);
        req_read[n] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) begin
            master_readdatavalid = (cnt > 0);
            master_readdata = $urandom;
            step();
        end
        master_readdatavalid = 1'b0;
        check("drain_empty", 64'(cnt), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int            g_seq[$];
    int            rdv_pct;
    bit            on_cmd[NR];
    bit            is_wr[NR];
    logic [DW-1:0] dvals[3];
    logic [NR-1:0] dexp[3];

    initial begin
        on_cmd = '{default: 1'b0};
        is_wr  = '{default: 1'b0};

        // Reset then idle
        do_reset();
        @(negedge clk);
        check("idle_waitreq", 64'(req_waitrequest), 64'b11);
        check("idle_mwrite", 64'(master_write), 64'd0);
        check("idle_mread", 64'(master_read), 64'd0);
        check("idle_pending", 64'(pending_reads), 64'd0);
        step();

        // Single write held off by the fabric for three cycles
        req_address[0]   = 28'h8000000;
        req_writedata[0] = 32'hF00BF00B;
        req_write[0]     = 1'b1;
        master_waitrequest = 1'b1;
        @(negedge clk);
        check("t2_arb_no_cmd", 64'(master_write), 64'd0);
        step();
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) master_waitrequest = 1'b0;
            @(negedge clk);
            check("t2_mwrite", 64'(master_write), 64'd1);
            check("t2_addr", 64'(master_address), 64'h8000000);
            check("t2_wait0", 64'(req_waitrequest[0]), 64'(c != 4));
            step();
        end
        req_write[0] = 1'b0;
        @(negedge clk);
        check("t2_back_arb", 64'(master_write), 64'd0);
        check("t2_waitreq", 64'(req_waitrequest), 64'b11);

        // Both requesters writing continuously: grants alternate from requester 0
        do_reset();
        req_address[0] = 28'h0000100;
        req_address[1] = 28'h0000200;
        req_write = 2'b11;
        for (int i = 0; i < 24 && g_seq.size() < 8; i++) begin
            @(negedge clk);
            if (!req_waitrequest[0]) g_seq.push_back(0);
            else if (!req_waitrequest[1]) g_seq.push_back(1);
            step();
        end
        req_write = 2'b00;
        check("t3_count", 64'(g_seq.size()), 64'd8);
        for (int i = 0; i < g_seq.size(); i++) check("t3_grant", 64'(g_seq[i]), 64'(i % 2));

        // Fill the tag FIFO from requester 1; fifth read stalls until a response drains one
        do_reset();
        req_address[1] = 28'h0000040;
        req_read[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pending_reads == 4) break;
            step();
        end
        check("t4_full", 64'(pending_reads), 64'd4);
        step();
        @(negedge clk);
        check("t4_stall_mread", 64'(master_read), 64'd0);
        check("t4_stall_wait", 64'(req_waitrequest[1]), 64'd1);
        step();
        master_readdatavalid = 1'b1;
        master_readdata = 32'hDEADF00B;
        @(negedge clk);
        check("t4_rdv_vec", 64'(req_readdatavalid), 64'b10);
        check("t4_rdv_data", 64'(req_readdata), 64'hDEADF00B);
        step();
        master_readdatavalid = 1'b0;
        @(negedge clk);
        check("t4_fifth_read", 64'(master_read), 64'd1);
        step();
        req_read[1] = 1'b0;
        drain();

        // Interleaved reads routed back in issue order; push and pop in the same cycle
        issue_read(0);
        issue_read(1);
        issue_read(0);
        dvals = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
        dexp  = '{2'b01, 2'b10, 2'b01};
        for (int k = 0; k < 3; k++) begin
            master_readdatavalid = 1'b1;
            master_readdata = dvals[k];
            @(negedge clk);
            check("t5_route", 64'(req_readdatavalid), 64'(dexp[k]));
            check("t5_data", 64'(req_readdata), 64'(dvals[k]));
            step();
        end
        master_readdatavalid = 1'b0;
        issue_read(0);
        req_read[1] = 1'b1;
        step();
        master_readdatavalid = 1'b1;
        master_readdata = 32'h12345678;
        @(negedge clk);
        check("t5_pushpop_accept", 64'(req_waitrequest[1]), 64'd0);
        check("t5_pushpop_rdv", 64'(req_readdatavalid), 64'b01);
        step();
        req_read[1] = 1'b0;
        master_readdatavalid = 1'b0;
        @(negedge clk);
        check("t5_pushpop_count", 64'(pending_reads), 64'd1);
        step();
        drain();

        // Orphan readdatavalid, then async reset in the middle of a stalled command
        master_readdatavalid = 1'b1;
        @(negedge clk);
        check("t6_orphan_vec", 64'(req_readdatavalid), 64'd0);
        step();
        master_readdatavalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t6_err_sticky", 64'(err_orphan_rdv), 64'd1);
            step();
        end
        issue_read(1);
        req_write[0] = 1'b1;
        master_waitrequest = 1'b1;
        step();
        @(negedge clk);
        check("t6_own_write", 64'(master_write), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_mwrite", 64'(master_write), 64'd0);
        check("t6_rst_waitreq", 64'(req_waitrequest), 64'b11);
        check("t6_rst_pending", 64'(pending_reads), 64'd0);
        check("t6_rst_err", 64'(err_orphan_rdv), 64'd0);
        do_reset();

        // Randomized traffic against the reference model
        rdv_pct = 40;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 200 == 0) rdv_pct = $urandom_range(80, 5);
            for (int n = 0; n < NR; n++) begin
                if (on_cmd[n] && acc_vec[n]) on_cmd[n] = 1'b0;
                if (!on_cmd[n] && $urandom_range(99) < 40) begin
                    on_cmd[n] = 1'b1;
                    is_wr[n]  = 1'($urandom_range(1));
                    req_address[n]   = AW'($urandom);
                    req_writedata[n] = $urandom;
                end
                req_write[n] = on_cmd[n] & is_wr[n];
                req_read[n]  = on_cmd[n] & ~is_wr[n];
            end
            master_waitrequest   = ($urandom_range(99) < 25);
            master_readdatavalid = (cnt > 0) && ($urandom_range(99) < rdv_pct);
            master_readdata      = $urandom;
            step();
        end
        req_write = '0;
        req_read  = '0;
        master_waitrequest = 1'b0;
        step();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
